// File: rtl/calc_entry_controller.sv
// Calculator key-entry and sequencing FSM: builds decimal operands from keypad
// codes, issues ALU requests and tracks the displayed value / error flag.
module calc_entry_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_key_data,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic             i_res_valid,
  input  logic [WIDTH-1:0] i_res_value,
  input  logic             i_res_error,
  output logic [WIDTH-1:0] o_disp_value,
  output logic             o_disp_error
);

  typedef enum logic [2:0] {
    ENTER_A, OP_PEND, ENTER_B, ISSUE, WAIT_RES, RESULT, ERROR
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, w_a_nx, w_b_nx;
  logic [1:0]       r_op, r_next_op, w_op_nx, w_next_op_nx;
  logic             r_chain, w_chain_nx;
  logic [WIDTH-1:0] r_disp, w_disp_nx;
  logic             r_err, w_err_nx;

  logic             w_acc, w_is_dig, w_dig_ok, w_is_ac, w_is_op, w_is_eq;
  logic [3:0]       w_dig;
  logic [1:0]       w_key_op;
  logic [WIDTH+3:0] w_a_ext, w_b_ext;
  logic             w_a_fit, w_b_fit;

  assign o_key_ready = (r_state != ISSUE) && (r_state != WAIT_RES);
  assign w_acc       = i_key_valid && o_key_ready;

  assign w_is_dig = ~i_key_data[4];
  assign w_dig    = i_key_data[3:0];
  assign w_dig_ok = w_is_dig && (w_dig <= 4'd9);
  assign w_is_ac  = (i_key_data == 5'b10000);
  assign w_is_op  = (i_key_data >= 5'b10001) && (i_key_data <= 5'b10100);
  assign w_is_eq  = (i_key_data == 5'b10101);
  assign w_key_op = i_key_data[1:0] - 2'd1;

  // old*10 + d computed 4 bits wider so overflow shows in the top bits
  assign w_a_ext = ({4'b0, r_a} << 3) + ({4'b0, r_a} << 1) + {{WIDTH{1'b0}}, w_dig};
  assign w_b_ext = ({4'b0, r_b} << 3) + ({4'b0, r_b} << 1) + {{WIDTH{1'b0}}, w_dig};
  assign w_a_fit = (w_a_ext[WIDTH+3:WIDTH] == 4'd0);
  assign w_b_fit = (w_b_ext[WIDTH+3:WIDTH] == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ENTER_A;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= 2'b00;
      r_next_op <= 2'b00;
      r_chain   <= 1'b0;
      r_disp    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_a       <= w_a_nx;
      r_b       <= w_b_nx;
      r_op      <= w_op_nx;
      r_next_op <= w_next_op_nx;
      r_chain   <= w_chain_nx;
      r_disp    <= w_disp_nx;
      r_err     <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_a_nx       = r_a;
    w_b_nx       = r_b;
    w_op_nx      = r_op;
    w_next_op_nx = r_next_op;
    w_chain_nx   = r_chain;
    if (w_acc && w_is_ac) begin
      w_a_nx     = '0;
      w_b_nx     = '0;
      w_op_nx    = 2'b00;
      w_state_nx = ENTER_A;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_acc && w_dig_ok && w_a_fit) w_a_nx = w_a_ext[WIDTH-1:0];
          else if (w_acc && w_is_op) begin
            w_op_nx    = w_key_op;
            w_b_nx     = '0;
            w_state_nx = OP_PEND;
          end
        end
        OP_PEND: begin
          if (w_acc && w_dig_ok) begin
            w_b_nx     = {{(WIDTH-4){1'b0}}, w_dig};
            w_state_nx = ENTER_B;
          end else if (w_acc && w_is_op) w_op_nx = w_key_op;
        end
        ENTER_B: begin
          if (w_acc && w_dig_ok && w_b_fit) w_b_nx = w_b_ext[WIDTH-1:0];
          else if (w_acc && w_is_eq) begin
            w_chain_nx = 1'b0;
            w_state_nx = ISSUE;
          end else if (w_acc && w_is_op) begin
            w_chain_nx   = 1'b1;
            w_next_op_nx = w_key_op;
            w_state_nx   = ISSUE;
          end
        end
        ISSUE: if (i_alu_ready) w_state_nx = WAIT_RES;
        WAIT_RES: begin
          if (i_res_valid) begin
            if (i_res_error) w_state_nx = ERROR;
            else if (r_chain) begin
              w_a_nx     = i_res_value;
              w_op_nx    = r_next_op;
              w_b_nx     = '0;
              w_state_nx = OP_PEND;
            end else begin
              w_a_nx     = i_res_value;
              w_state_nx = RESULT;
            end
          end
        end
        RESULT: begin
          if (w_acc && w_dig_ok) begin
            w_a_nx     = {{(WIDTH-4){1'b0}}, w_dig};
            w_state_nx = ENTER_A;
          end else if (w_acc && w_is_op) begin
            w_op_nx    = w_key_op;
            w_b_nx     = '0;
            w_state_nx = OP_PEND;
          end
        end
        default: ;
      endcase
    end
  end

  // display follows the destination state; held while a request is in flight
  always_comb begin
    w_disp_nx = r_disp;
    w_err_nx  = (w_state_nx == ERROR);
    case (w_state_nx)
      ENTER_A, OP_PEND, RESULT: w_disp_nx = w_a_nx;
      ENTER_B:                  w_disp_nx = w_b_nx;
      ERROR:                    w_disp_nx = '0;
      default:                  ;
    endcase
  end

  assign o_alu_a      = r_a;
  assign o_alu_b      = r_b;
  assign o_alu_op     = r_op;
  assign o_alu_valid  = (r_state == ISSUE);
  assign o_disp_value = r_disp;
  assign o_disp_error = r_err;

endmodule

// File: tb/tb_calc_entry_controller.sv
// Bench for calc_entry_controller: key vectors from a table, ALU requests
// scored against a queue of expected requests, plus backpressure/reset cases.
module tb_calc_entry_controller;
  localparam int W = 16;
  localparam logic [4:0] AC = 5'h10, ADD = 5'h11, SUB = 5'h12, MUL = 5'h13,
                         DIV = 5'h14, EQ = 5'h15;

  logic         clk = 0, rst_n = 0;
  logic [4:0]   i_key_data = '0;
  logic         i_key_valid = 0, o_key_ready;
  logic [W-1:0] o_alu_a, o_alu_b;
  logic [1:0]   o_alu_op;
  logic         o_alu_valid, i_alu_ready;
  logic         i_res_valid = 0, i_res_error = 0;
  logic [W-1:0] i_res_value = '0;
  logic [W-1:0] o_disp_value;
  logic         o_disp_error;
  logic         alu_rdy = 1;

  int checks = 0, errors = 0;

  typedef struct {logic [W-1:0] a, b; logic [1:0] op;} req_t;
  typedef struct {
    logic [4:0] key; bit req; logic [W-1:0] ra, rb; logic [1:0] rop;
    logic [W-1:0] disp; bit err;
  } vec_t;
  req_t exq[$];
  vec_t vt[$];

  assign i_alu_ready = alu_rdy;
  always #5 clk = ~clk;

  calc_entry_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i_key_data(i_key_data), .i_key_valid(i_key_valid),
    .o_key_ready(o_key_ready), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
    .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .i_res_valid(i_res_valid), .i_res_value(i_res_value), .i_res_error(i_res_error),
    .o_disp_value(o_disp_value), .o_disp_error(o_disp_error));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] k, input bit rq, input int ra, input int rb,
                     input int rop, input int disp, input bit err);
    vec_t v;
    v.key = k; v.req = rq; v.ra = W'(ra); v.rb = W'(rb); v.rop = 2'(rop);
    v.disp = W'(disp); v.err = err;
    vt.push_back(v);
  endtask

  task automatic send(input logic [4:0] k, input bit wait_res);
    int n;
    @(negedge clk);
    i_key_data = k; i_key_valid = 1;
    n = 0;
    while (!o_key_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("key_accept_timeout", 0, 1);
    @(posedge clk); #1 i_key_valid = 0;
    if (wait_res) begin
      n = 0;
      @(negedge clk);
      while (!o_key_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("result_timeout", 0, 1);
    end
  endtask

  // ALU model: pops the expected request on handshake and answers 2 cycles later
  initial begin
    req_t e;
    logic [W:0]     s;
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    logic           er;
    forever begin
      @(posedge clk);
      if (rst_n && o_alu_valid && i_alu_ready) begin
        if (exq.size() == 0) begin
          check("unexpected_alu_req", 1, 0);
        end else begin
          e = exq.pop_front();
          check("alu_a", o_alu_a, e.a);
          check("alu_b", o_alu_b, e.b);
          check("alu_op", o_alu_op, e.op);
          r = '0; er = 0;
          case (e.op)
            2'd0: begin s = {1'b0, e.a} + {1'b0, e.b}; r = s[W-1:0]; er = s[W]; end
            2'd1: begin r = e.a - e.b; er = (e.a < e.b); end
            2'd2: begin p = e.a * e.b; r = p[W-1:0]; er = (p[2*W-1:W] != 0); end
            default: begin er = (e.b == 0); r = er ? '0 : e.a / e.b; end
          endcase
          repeat (2) @(negedge clk);
          i_res_valid = 1; i_res_value = r; i_res_error = er;
          @(negedge clk);
          i_res_valid = 0; i_res_error = 0;
        end
      end
    end
  end

  initial begin
    // key, req, a, b, op, disp, err
    add(5'd1, 0, 0, 0, 0, 1, 0);  add(5'd2, 0, 0, 0, 0, 12, 0);
    add(ADD, 0, 0, 0, 0, 12, 0);  add(5'd3, 0, 0, 0, 0, 3, 0);
    add(EQ, 1, 12, 3, 0, 15, 0);  add(5'd7, 0, 0, 0, 0, 7, 0);
    add(AC, 0, 0, 0, 0, 0, 0);
    add(5'd5, 0, 0, 0, 0, 5, 0);  add(MUL, 0, 0, 0, 0, 5, 0);
    add(5'd4, 0, 0, 0, 0, 4, 0);  add(SUB, 1, 5, 4, 2, 20, 0);
    add(5'd2, 0, 0, 0, 0, 2, 0);  add(EQ, 1, 20, 2, 1, 18, 0);
    add(AC, 0, 0, 0, 0, 0, 0);
    add(5'd8, 0, 0, 0, 0, 8, 0);  add(DIV, 0, 0, 0, 0, 8, 0);
    add(5'd0, 0, 0, 0, 0, 0, 0);  add(EQ, 1, 8, 0, 3, 0, 1);
    add(5'd3, 0, 0, 0, 0, 0, 1);  add(ADD, 0, 0, 0, 0, 0, 1);
    add(AC, 0, 0, 0, 0, 0, 0);
    add(5'd6, 0, 0, 0, 0, 6, 0);  add(5'd5, 0, 0, 0, 0, 65, 0);
    add(5'd5, 0, 0, 0, 0, 655, 0); add(5'd3, 0, 0, 0, 0, 6553, 0);
    add(5'd5, 0, 0, 0, 0, 65535, 0); add(5'd9, 0, 0, 0, 0, 65535, 0);
    add(5'd12, 0, 0, 0, 0, 65535, 0); add(AC, 0, 0, 0, 0, 0, 0);
    add(5'd4, 0, 0, 0, 0, 4, 0);  add(ADD, 0, 0, 0, 0, 4, 0);
    add(SUB, 0, 0, 0, 0, 4, 0);   add(5'd1, 0, 0, 0, 0, 1, 0);
    add(EQ, 1, 4, 1, 1, 3, 0);    add(MUL, 0, 0, 0, 0, 3, 0);
    add(5'd2, 0, 0, 0, 0, 2, 0);  add(EQ, 1, 3, 2, 2, 6, 0);
    add(AC, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("rst_ready", o_key_ready, 1);
    check("rst_alu_valid", o_alu_valid, 0);
    check("rst_disp", o_disp_value, 0);
    check("rst_err", o_disp_error, 0);
    check("rst_alu_op", o_alu_op, 0);
    rst_n = 1;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].req) begin
        req_t q;
        q.a = vt[i].ra; q.b = vt[i].rb; q.op = vt[i].rop;
        exq.push_back(q);
      end
      send(vt[i].key, vt[i].req);
      @(negedge clk);
      check($sformatf("vec%0d_disp", i), o_disp_value, vt[i].disp);
      check($sformatf("vec%0d_err", i), o_disp_error, vt[i].err);
    end

    // ALU backpressure: request held stable, keys stalled until result
    begin
      req_t q;
      alu_rdy = 0;
      send(5'd9, 0); send(ADD, 0); send(5'd1, 0);
      q.a = 9; q.b = 1; q.op = 0; exq.push_back(q);
      send(EQ, 0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("bp_valid", o_alu_valid, 1);
        check("bp_a", o_alu_a, 9);
        check("bp_b", o_alu_b, 1);
        check("bp_op", o_alu_op, 0);
        check("bp_ready", o_key_ready, 0);
      end
      alu_rdy = 1;
      send(5'd3, 0);
      @(negedge clk);
      check("bp_held_key_disp", o_disp_value, 3);
      check("bp_queue_empty", exq.size(), 0);
      send(AC, 0);
    end

    // reset while a request is outstanding, then a stray result strobe
    alu_rdy = 0;
    send(5'd2, 0); send(ADD, 0); send(5'd3, 0); send(EQ, 0);
    @(negedge clk);
    check("issue_valid", o_alu_valid, 1);
    #2 rst_n = 0;
    #1 check("rst_mid_valid", o_alu_valid, 0);
    check("rst_mid_disp", o_disp_value, 0);
    @(negedge clk);
    rst_n = 1; alu_rdy = 1;
    @(negedge clk);
    check("rst_mid_ready", o_key_ready, 1);
    i_res_valid = 1; i_res_value = 16'd99;
    @(negedge clk);
    i_res_valid = 0;
    @(negedge clk);
    check("stray_strobe_disp", o_disp_value, 0);
    check("stray_strobe_err", o_disp_error, 0);
    send(5'd4, 0);
    @(negedge clk);
    check("post_rst_key", o_disp_value, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/calc_entry_controller.md
Name: calc_entry_controller

Overview:
Sits directly downstream of the keypad scanner. It consumes 5-bit key codes over a valid/ready handshake and builds decimal operands. It dispatches arithmetic requests to the ALU over a second valid/ready handshake and maintains the value and error flag shown on the display. All keys flow through this block; it is the calculator's entry and sequencing FSM.

Parameters:
WIDTH, 16, operand/result width in bits (unsigned)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
i_key_data  input  5  key code: 0_dddd = digit value 0-15; 10_000 AC, 10_001 +, 10_010 -, 10_011 *, 10_100 /, 10_101 =
i_key_valid  input  1  key code valid
o_key_ready  output  1  controller can accept a key
o_alu_a  output  WIDTH  operand A
o_alu_b  output  WIDTH  operand B
o_alu_op  output  2  00 add, 01 sub, 10 mul, 11 div
o_alu_valid  output  1  ALU request valid
i_alu_ready  input  1  ALU accepts request
i_res_valid  input  1  one-cycle result strobe
i_res_value  input  WIDTH  result
i_res_error  input  1  result invalid (div-by-zero, overflow, underflow); sampled with i_res_valid
o_disp_value  output  WIDTH  value to display
o_disp_error  output  1  display error indicator

Behaviour:
- Reset values: state ENTER_A; A=B=0; op=00; o_alu_valid=0; o_disp_value=0; o_disp_error=0; o_key_ready=1.
- Key accepted on the clk edge where i_key_valid && o_key_ready. o_key_ready is a combinational decode of state: 0 in ISSUE/WAIT_RES, 1 otherwise.
- All registered outputs update on the accepting edge (1-cycle latency).
- Digit d (code <16): d>9 is consumed and dropped. Otherwise new = old*10+d. If new > 2^WIDTH-1, the digit is dropped and the operand is unchanged.
- States:
  - ENTER_A: digit→A update. Op→store op, B=0, go OP_PEND. '=' ignored.
  - OP_PEND: digit→B=d, go ENTER_B. Op→replace stored op. '=' ignored.
  - ENTER_B: digit→B update. '='→go ISSUE, chain=0. Op→go ISSUE, chain=1, next_op=new op.
  - ISSUE: o_alu_valid=1. o_alu_a/b/op are held stable until the edge with i_alu_ready=1, then o_alu_valid drops and the state goes to WAIT_RES.
  - WAIT_RES: on i_res_valid:
    - If error: go ERROR, o_disp_error=1.
    - Else if chain: A=result, op=next_op, B=0, go OP_PEND.
    - Else: A=result, go RESULT.
    - i_res_valid in any other state is ignored.
  - RESULT: digit→A=d (d≤9), go ENTER_A. Op→store op, B=0, go OP_PEND. '=' ignored.
  - ERROR: only AC is honoured; all other keys are consumed and dropped.
- AC, in any state with o_key_ready=1: A=B=0, op=00, error=0, go ENTER_A.
- AC cannot arrive in ISSUE/WAIT_RES because ready is low there; it stalls upstream.
- o_disp_value:
  - A in ENTER_A/OP_PEND/RESULT.
  - B in ENTER_B.
  - Unchanged in ISSUE/WAIT_RES.
  - 0 in ERROR.
- o_disp_error=1 only in ERROR.
- rst_n assertion mid-request clears state immediately. An ALU strobe arriving after reset is ignored.

Test Plan:
- Keys 1,2,+,3,= with i_alu_ready=1 → o_alu_valid one cycle with a=12, b=3, op=00. Strobe result 15 → o_disp_value=15, state RESULT. Then key 7 → display 7.
- Keys 5,*,4,-,2,= → first request a=5, b=4, op=10. Result 20 → display 20, OP_PEND. Second request a=20, b=2, op=01. Result 18 → display 18.
- Keys 8,/,0,= with ALU returning i_res_error=1 → o_disp_error=1, display 0. Keys 3,+ dropped, error stays set. AC → error=0, display 0, ENTER_A.
- Backpressure: i_alu_ready low 3 cycles after '=' → o_alu_valid and a/b/op stable for all 3 cycles. o_key_ready=0 until i_res_valid; a key held valid upstream is accepted the cycle after the result.
- WIDTH=16, keys 6,5,5,3,5,9 → display 65535 after the fifth key; 9 dropped, display stays 65535. Key code 12 → dropped, no change.
- Keys 4,+,-,AC → op replaced with 01, then AC clears to display 0. Assert rst_n low during ISSUE → o_alu_valid=0 immediately, o_key_ready=1 after release.
